// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared state encoding, field limits and wrap helpers for the watch core
// Optional feature macro: WATCH_HOUR12_EN (12-hour range 1..12, reset 12).
// Without it the hour range is 0..23 with reset value 0.
`timescale 1ns/1ps

package watch_pkg;

  // Edit-mode state; the encoding is exported directly on set_mode.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } watch_state_e;

  // All time fields share one 7-bit width so the same helpers and the
  // same digit splitter serve every field.
  localparam logic [6:0] MSEC_MAX = 7'd99;
  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;

`ifdef WATCH_HOUR12_EN
  localparam logic [6:0] HOUR_MIN   = 7'd1;
  localparam logic [6:0] HOUR_MAX   = 7'd12;
  localparam logic [6:0] HOUR_RESET = 7'd12;
`else
  localparam logic [6:0] HOUR_MIN   = 7'd0;
  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] HOUR_RESET = 7'd0;
`endif

  // Increment within [lo, hi], wrapping hi -> lo.
  function automatic logic [6:0] wrap_inc(input logic [6:0] v,
                                          input logic [6:0] lo,
                                          input logic [6:0] hi);
    if (v >= hi) begin
      return lo;
    end
    return v + 7'd1;
  endfunction

  // Decrement within [lo, hi], wrapping lo -> hi.
  function automatic logic [6:0] wrap_dec(input logic [6:0] v,
                                          input logic [6:0] lo,
                                          input logic [6:0] hi);
    if (v <= lo) begin
      return hi;
    end
    return v - 7'd1;
  endfunction

endpackage

// File: rtl/digit_splitter.sv
// rtl/digit_splitter.sv - binary 0..99 to two BCD digits
// Ports:
//   bin   in  7  binary value, expected range 0..99
//   tens  out 4  BCD tens digit
//   ones  out 4  BCD ones digit
`timescale 1ns/1ps

module digit_splitter (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Constant-divisor divide/modulo; for a 0..99 input both results fit in
  // four bits, so the upper quotient/remainder bits are always zero.
  assign tens = 4'(bin / 7'd10);
  assign ones = 4'(bin % 7'd10);

endmodule

// File: rtl/watch_digit_core.sv
// rtl/watch_digit_core.sv - 10 ms resolution timekeeper with button-driven field editing
// Optional feature macro: WATCH_HOUR12_EN (selects 12-hour range through watch_pkg).
// Parameters:
//   CLK_HZ   input clock frequency
//   TICK_HZ  msec-field increment rate, CLK_HZ/TICK_HZ must be >= 2
// Ports:
//   clk                          in   1  system clock
//   rst                          in   1  asynchronous active-low reset
//   btn_mode / btn_up / btn_down in   1  debounced levels, acted on at rising edges
//   msec                         out  7  binary msec count 0..99
//   digit_<field>_10/_1          out  4  BCD tens/ones for msec, sec, min, hour
//   set_mode                     out  2  0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR
`timescale 1ns/1ps

module watch_digit_core
  import watch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [6:0] msec,
  output logic [3:0] digit_msec_1,
  output logic [3:0] digit_msec_10,
  output logic [3:0] digit_sec_1,
  output logic [3:0] digit_sec_10,
  output logic [3:0] digit_min_1,
  output logic [3:0] digit_min_10,
  output logic [3:0] digit_hour_1,
  output logic [3:0] digit_hour_10,
  output logic [1:0] set_mode
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  watch_state_e   state_r;
  logic [PW-1:0]  presc_r;
  logic [6:0]     msec_r;
  logic [6:0]     sec_r;
  logic [6:0]     min_r;
  logic [6:0]     hour_r;

  logic mode_prev;
  logic up_prev;
  logic down_prev;

  logic mode_edge;
  logic up_edge;
  logic down_edge;
  logic edit_up;
  logic edit_down;
  logic tick;

  // Previous-value registers reset to 1: a button already held when reset
  // releases must not be seen as a fresh press.
  assign mode_edge = btn_mode & ~mode_prev;
  assign up_edge   = btn_up   & ~up_prev;
  assign down_edge = btn_down & ~down_prev;

  // Opposing presses in the same cycle cancel out.
  assign edit_up   = up_edge & ~down_edge;
  assign edit_down = down_edge & ~up_edge;

  assign tick = (state_r == RUN) && (presc_r == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_prev <= 1'b1;
      up_prev   <= 1'b1;
      down_prev <= 1'b1;
    end else begin
      mode_prev <= btn_mode;
      up_prev   <= btn_up;
      down_prev <= btn_down;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
      presc_r <= '0;
      msec_r  <= '0;
      sec_r   <= '0;
      min_r   <= '0;
      hour_r  <= HOUR_RESET;
    end else if (mode_edge) begin
      // A mode press wins over any edit or tick in the same cycle.
      unique case (state_r)
        RUN: begin
          state_r <= SET_SEC;
          msec_r  <= '0;
          presc_r <= '0;
        end
        SET_SEC:  state_r <= SET_MIN;
        SET_MIN:  state_r <= SET_HOUR;
        SET_HOUR: begin
          state_r <= RUN;
          presc_r <= '0;
        end
        default:  state_r <= RUN;
      endcase
    end else if (state_r == RUN) begin
      if (tick) begin
        presc_r <= '0;
        // Full carry chain resolves in a single cycle.
        if (msec_r >= MSEC_MAX) begin
          msec_r <= '0;
          if (sec_r >= SEC_MAX) begin
            sec_r <= '0;
            if (min_r >= MIN_MAX) begin
              min_r  <= '0;
              hour_r <= wrap_inc(hour_r, HOUR_MIN, HOUR_MAX);
            end else begin
              min_r <= min_r + 7'd1;
            end
          end else begin
            sec_r <= sec_r + 7'd1;
          end
        end else begin
          msec_r <= msec_r + 7'd1;
        end
      end else begin
        presc_r <= presc_r + 1'b1;
      end
    end else begin
      // Edit states: prescaler and msec are frozen; wraps stay local.
      unique case (state_r)
        SET_SEC: begin
          if (edit_up) begin
            sec_r <= wrap_inc(sec_r, 7'd0, SEC_MAX);
          end else if (edit_down) begin
            sec_r <= wrap_dec(sec_r, 7'd0, SEC_MAX);
          end
        end
        SET_MIN: begin
          if (edit_up) begin
            min_r <= wrap_inc(min_r, 7'd0, MIN_MAX);
          end else if (edit_down) begin
            min_r <= wrap_dec(min_r, 7'd0, MIN_MAX);
          end
        end
        SET_HOUR: begin
          if (edit_up) begin
            hour_r <= wrap_inc(hour_r, HOUR_MIN, HOUR_MAX);
          end else if (edit_down) begin
            hour_r <= wrap_dec(hour_r, HOUR_MIN, HOUR_MAX);
          end
        end
        default: ;
      endcase
    end
  end

  assign msec     = msec_r;
  assign set_mode = state_r;

  digit_splitter u_split_msec (
    .bin  (msec_r),
    .tens (digit_msec_10),
    .ones (digit_msec_1)
  );

  digit_splitter u_split_sec (
    .bin  (sec_r),
    .tens (digit_sec_10),
    .ones (digit_sec_1)
  );

  digit_splitter u_split_min (
    .bin  (min_r),
    .tens (digit_min_10),
    .ones (digit_min_1)
  );

  digit_splitter u_split_hour (
    .bin  (hour_r),
    .tens (digit_hour_10),
    .ones (digit_hour_1)
  );

endmodule

// File: tb/tb_watch_digit_core.sv
// tb/tb_watch_digit_core.sv - scoreboard bench for watch_digit_core (DIV = 10)
`timescale 1ns/1ps

module tb_watch_digit_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [6:0] msec;
  logic [3:0] digit_msec_1;
  logic [3:0] digit_msec_10;
  logic [3:0] digit_sec_1;
  logic [3:0] digit_sec_10;
  logic [3:0] digit_min_1;
  logic [3:0] digit_min_10;
  logic [3:0] digit_hour_1;
  logic [3:0] digit_hour_10;
  logic [1:0] set_mode;

  watch_digit_core #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_mode      (btn_mode),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .msec          (msec),
    .digit_msec_1  (digit_msec_1),
    .digit_msec_10 (digit_msec_10),
    .digit_sec_1   (digit_sec_1),
    .digit_sec_10  (digit_sec_10),
    .digit_min_1   (digit_min_1),
    .digit_min_10  (digit_min_10),
    .digit_hour_1  (digit_hour_1),
    .digit_hour_10 (digit_hour_10),
    .set_mode      (set_mode)
  );

  always #5 clk = ~clk;

`ifdef WATCH_HOUR12_EN
  localparam int H_MIN = 1;
  localparam int H_MAX = 12;
  localparam int H_RST = 12;
`else
  localparam int H_MIN = 0;
  localparam int H_MAX = 23;
  localparam int H_RST = 0;
`endif

  typedef struct {
    string tag;
    int    ms;
    int    s;
    int    m;
    int    h;
    int    md;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference time held by the bench.
  int e_ms, e_s, e_m, e_h, e_md;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_inc(input int v, input int lo, input int hi);
    return ((v - lo + 1) % (hi - lo + 1)) + lo;
  endfunction

  function automatic int m_dec(input int v, input int lo, input int hi);
    return ((v - lo + (hi - lo)) % (hi - lo + 1)) + lo;
  endfunction

  task automatic m_tick();
    e_ms = (e_ms + 1) % 100;
    if (e_ms == 0) begin
      e_s = (e_s + 1) % 60;
      if (e_s == 0) begin
        e_m = (e_m + 1) % 60;
        if (e_m == 0) e_h = m_inc(e_h, H_MIN, H_MAX);
      end
    end
  endtask

  task automatic sb_push(input string tag);
    exp_t e;
    e.tag = tag; e.ms = e_ms; e.s = e_s; e.m = e_m; e.h = e_h; e.md = e_md;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_underflow", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({e.tag, ".set_mode"}, 32'(set_mode),      32'(e.md));
    check_eq({e.tag, ".msec"},     32'(msec),          32'(e.ms));
    check_eq({e.tag, ".ms10"},     32'(digit_msec_10), 32'(e.ms / 10));
    check_eq({e.tag, ".ms1"},      32'(digit_msec_1),  32'(e.ms % 10));
    check_eq({e.tag, ".sec10"},    32'(digit_sec_10),  32'(e.s / 10));
    check_eq({e.tag, ".sec1"},     32'(digit_sec_1),   32'(e.s % 10));
    check_eq({e.tag, ".min10"},    32'(digit_min_10),  32'(e.m / 10));
    check_eq({e.tag, ".min1"},     32'(digit_min_1),   32'(e.m % 10));
    check_eq({e.tag, ".hour10"},   32'(digit_hour_10), 32'(e.h / 10));
    check_eq({e.tag, ".hour1"},    32'(digit_hour_1),  32'(e.h % 10));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic observe(input string tag);
    sb_push(tag);
    sb_pop_check();
  endtask

  // One-cycle press: the expected result is queued when the button is
  // driven and checked after the capturing edge; release costs one cycle.
  task automatic pulse(input logic m, input logic u, input logic d, input string tag);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    sb_push(tag);
    step();
    sb_pop_check();
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    btn_mode = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    e_ms = 0; e_s = 0; e_m = 0; e_h = H_RST; e_md = 0;

    steps(3);
    observe("reset");

    // Release with btn_mode still held: no mode edge, first tick at cycle 10.
    rst = 1'b1;
    steps(5);
    btn_mode = 1'b0;
    steps(4);
    observe("pre_first_tick");
    step();
    e_ms = 1;
    observe("first_tick");

    steps(360);
    e_ms = 37;
    observe("run_ms37");

    e_md = 1; e_ms = 0;
    pulse(1'b1, 1'b0, 1'b0, "enter_set_sec");
    steps(100);
    observe("set_sec_hold");

    e_s = 1;  pulse(1'b0, 1'b1, 1'b0, "sec_up");
    e_s = 0;  pulse(1'b0, 1'b0, 1'b1, "sec_down");
    e_s = 59; pulse(1'b0, 1'b0, 1'b1, "sec_wrap_down");

    e_md = 2; pulse(1'b1, 1'b0, 1'b0, "enter_set_min");
    e_m = 59; pulse(1'b0, 1'b0, 1'b1, "min_wrap_down");
    e_m = 0;  pulse(1'b0, 1'b1, 1'b0, "min_wrap_up");
    e_m = 59; pulse(1'b0, 1'b0, 1'b1, "min_down");

    e_md = 3; pulse(1'b1, 1'b0, 1'b0, "enter_set_hour");
    e_h = m_inc(e_h, H_MIN, H_MAX); pulse(1'b0, 1'b1, 1'b0, "hour_up");
    e_h = m_dec(e_h, H_MIN, H_MAX); pulse(1'b0, 1'b0, 1'b1, "hour_down");
    pulse(1'b0, 1'b1, 1'b1, "hour_up_down_same");
    for (int i = 0; i < 24 && e_h != H_MAX; i++) begin
      e_h = m_inc(e_h, H_MIN, H_MAX);
      pulse(1'b0, 1'b1, 1'b0, "hour_to_max");
    end

    // Mode and up together: only the mode advances, prescaler restarts.
    e_md = 0;
    pulse(1'b1, 1'b1, 1'b0, "mode_up_same");
    steps(8);
    observe("restart_hold");
    step();
    m_tick();
    observe("restart_tick");

    steps(980);
    repeat (98) m_tick();
    observe("pre_rollover");
    steps(9);
    observe("pre_rollover_hold");
    step();
    m_tick();
    observe("rollover");

    pulse(1'b0, 1'b1, 1'b0, "run_up_ignored");
    pulse(1'b0, 1'b0, 1'b1, "run_down_ignored");

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b0;
    #1;
    e_ms = 0; e_s = 0; e_m = 0; e_h = H_RST; e_md = 0;
    observe("async_reset");
    steps(2);
    rst = 1'b1;
    steps(2);
    observe("after_reset_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
